// File: rtl/joypad_scanner_if.sv
// Pad-pin and game-side signal bundle for joypad_scanner.
// master = pads/game logic side, slave = scanner side.
interface joypad_scanner_if #(
  parameter int PORTS = 2
);
  logic [PORTS-1:0]    inp_up;
  logic [PORTS-1:0]    inp_down;
  logic [PORTS-1:0]    inp_left;
  logic [PORTS-1:0]    inp_right;
  logic [PORTS-1:0]    inp_a_b;
  logic [PORTS-1:0]    inp_c_s;
  logic [PORTS-1:0]    out_sel;
  logic [12*PORTS-1:0] out_buttons;
  logic [PORTS-1:0]    out_present;
  logic [PORTS-1:0]    out_six;
  logic                out_valid;

  modport master (
    output inp_up, inp_down, inp_left, inp_right, inp_a_b, inp_c_s,
    input  out_sel, out_buttons, out_present, out_six, out_valid
  );

  modport slave (
    input  inp_up, inp_down, inp_left, inp_right, inp_a_b, inp_c_s,
    output out_sel, out_buttons, out_present, out_six, out_valid
  );
endinterface

// File: rtl/joypad_scanner.sv
// Multi-port Sega 3/6-button joypad scanner: shared 8-phase select FSM, per-port lanes.
// Optional macro JOYPAD_SCANNER_DEBOUNCE_EN: commit buttons/six only when two scans agree.
module joypad_scanner_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  pins,     // {c_s, a_b, right, left, down, up}, active-low
  input  logic [3:0]  smp,      // sample strobes for phases 0, 1, 5, 6
  input  logic        commit,
  output logic [11:0] buttons,
  output logic        present,
  output logic        six
);
  logic [5:0]  s1, s2;
  logic [5:0]  p;
  logic [11:0] sc;
  logic        sc_pres, sc_six;
  logic [11:0] new_btn;
  logic        new_six;

  assign p       = ~s2;
  assign new_btn = sc_pres ? sc : 12'h000;
  assign new_six = sc_pres & sc_six;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= pins;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc      <= '0;
      sc_pres <= 1'b0;
      sc_six  <= 1'b0;
    end else begin
      if (smp[0]) sc[5:0] <= p;
      if (smp[1]) begin
        sc[7:6] <= p[5:4];
        sc_pres <= (s2[3:2] == 2'b00);
      end
      if (smp[2]) sc_six <= (s2[3:0] == 4'b0000);
      // Z/Y/X/Mode ride on the direction pins during the fourth high phase
      if (smp[3]) sc[11:8] <= sc_six ? p[3:0] : 4'h0;
    end
  end

`ifdef JOYPAD_SCANNER_DEBOUNCE_EN
  logic [12:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist    <= '0;
      buttons <= '0;
      six     <= 1'b0;
      present <= 1'b0;
    end else if (commit) begin
      hist    <= {new_six, new_btn};
      present <= sc_pres;
      if ({new_six, new_btn} == hist) begin
        buttons <= new_btn;
        six     <= new_six;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buttons <= '0;
      six     <= 1'b0;
      present <= 1'b0;
    end else if (commit) begin
      buttons <= new_btn;
      six     <= new_six;
      present <= sc_pres;
    end
  end
`endif
endmodule

module joypad_scanner #(
  parameter int PORTS         = 2,
  parameter int CLOCK_HZ      = 50000000,
  parameter int POLL_HZ       = 60,
  parameter int SETTLE_CYCLES = 500
) (
  input  logic            inp_clock,
  input  logic            inp_reset,
  joypad_scanner_if.slave bus
);
  localparam int POLL_CYCLES = CLOCK_HZ / POLL_HZ;
  localparam int PW          = $clog2(POLL_CYCLES);
  localparam int SW          = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, PHASE, COMMIT} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  poll_cnt;
  logic [SW-1:0]  settle_cnt;
  logic [2:0]     k;
  logic           poll_wrap, phase_end, in_phase, commit, sel;
  logic [3:0]     smp;
  logic [PORTS-1:0][11:0] btn;
  logic [PORTS-1:0]       pres, six;

  assign poll_wrap = (poll_cnt == PW'(POLL_CYCLES - 1));
  assign phase_end = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign in_phase  = (state_q == PHASE);
  assign commit    = (state_q == COMMIT);

  always_comb begin
    state_d = state_q;
    sel     = 1'b1;
    smp     = 4'b0000;
    case (state_q)
      IDLE:   if (poll_wrap) state_d = PHASE;
      PHASE: begin
        sel = ~k[0];
        if (phase_end) begin
          smp[0] = (k == 3'd0);
          smp[1] = (k == 3'd1);
          smp[2] = (k == 3'd5);
          smp[3] = (k == 3'd6);
          if (k == 3'd7) state_d = COMMIT;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inp_clock or posedge inp_reset) begin
    if (inp_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Poll counter free-runs so the start-to-start period never drifts
  always_ff @(posedge inp_clock or posedge inp_reset) begin
    if (inp_reset) begin
      poll_cnt      <= '0;
      settle_cnt    <= '0;
      k             <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      poll_cnt      <= poll_wrap ? '0 : poll_cnt + 1'b1;
      settle_cnt    <= (!in_phase || phase_end) ? '0 : settle_cnt + 1'b1;
      if (!in_phase)      k <= '0;
      else if (phase_end) k <= k + 3'd1;
      bus.out_valid <= commit;
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    joypad_scanner_lane u_lane (
      .clk     (inp_clock),
      .rst     (inp_reset),
      .pins    ({bus.inp_c_s[p], bus.inp_a_b[p], bus.inp_right[p],
                 bus.inp_left[p], bus.inp_down[p], bus.inp_up[p]}),
      .smp     (smp),
      .commit  (commit),
      .buttons (btn[p]),
      .present (pres[p]),
      .six     (six[p])
    );
  end

  assign bus.out_sel     = {PORTS{sel}};
  assign bus.out_buttons = btn;
  assign bus.out_present = pres;
  assign bus.out_six     = six;
endmodule
